// File: rtl/sram_initiator.sv
// ============================================================================
// sram_initiator
// ----------------------------------------------------------------------------
// Purpose:
//   Bridges a simple valid/ready host request/response channel onto a
//   single-port synchronous-write SRAM with a combinational read port.
//   Each host request becomes exactly one SRAM access followed by one
//   response. A memory-fill engine can also sweep fill_value across
//   addresses 0..FILL_LAST, one word per cycle.
//
// Ports:
//   clk, rstn            clock (rising edge) and async active-low reset
//   i_req_valid          host request valid
//   o_req_ready          initiator can accept a request this cycle
//   i_req_we             byte write enables, 4'h0 means read
//   i_req_addr           request word address
//   i_req_wdata          request write data
//   o_rsp_valid          response valid
//   i_rsp_ready          host accepts the response
//   o_rsp_rdata          read data, 0 for write responses
//   i_fill_start         start a memory fill
//   i_fill_value         fill data, sampled when the fill is accepted
//   o_fill_busy          fill in progress
//   o_fill_done          one-cycle pulse after the last fill write
//   o_mem_cs             SRAM chip select
//   o_mem_we             SRAM byte write enables
//   o_mem_addr           SRAM word address
//   o_mem_wdata          SRAM write data
//   i_mem_rdata          SRAM read data, valid in the cycle it is selected
// ============================================================================
module sram_initiator #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned FILL_LAST = (1 << ADDRWIDTH) - 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [3:0]           i_req_we,
    input  logic [ADDRWIDTH-1:0] i_req_addr,
    input  logic [DATAWIDTH-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATAWIDTH-1:0] o_rsp_rdata,
    input  logic                 i_fill_start,
    input  logic [DATAWIDTH-1:0] i_fill_value,
    output logic                 o_fill_busy,
    output logic                 o_fill_done,
    output logic                 o_mem_cs,
    output logic [3:0]           o_mem_we,
    output logic [ADDRWIDTH-1:0] o_mem_addr,
    output logic [DATAWIDTH-1:0] o_mem_wdata,
    input  logic [DATAWIDTH-1:0] i_mem_rdata
);

    localparam logic [ADDRWIDTH-1:0] LP_FILL_LAST = ADDRWIDTH'(FILL_LAST);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FILL
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDRWIDTH-1:0]   r_fill_cnt;
    logic [ADDRWIDTH-1:0]   w_fill_cnt_nxt;
    logic                   w_fill_last;

    logic                   r_mem_cs;
    logic [3:0]             r_mem_we;
    logic [ADDRWIDTH-1:0]   r_mem_addr;
    logic [DATAWIDTH-1:0]   r_mem_wdata;
    logic                   w_mem_cs_nxt;
    logic [3:0]             w_mem_we_nxt;
    logic [ADDRWIDTH-1:0]   w_mem_addr_nxt;
    logic [DATAWIDTH-1:0]   w_mem_wdata_nxt;

    logic [DATAWIDTH-1:0]   r_rsp_rdata;
    logic                   r_fill_done;

    assign w_fill_last = (r_fill_cnt == LP_FILL_LAST);

    // Next-state logic. The SRAM bus is registered, so the value it must
    // carry in the next state is computed here alongside the transition:
    // the request fields are captured straight into the bus registers, and
    // during a fill the bus write-data register itself holds the fill value.
    always_comb begin
        w_state_nxt     = r_state;
        w_fill_cnt_nxt  = r_fill_cnt;
        w_mem_cs_nxt    = 1'b0;
        w_mem_we_nxt    = 4'h0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (i_fill_start) begin
                    w_state_nxt     = FILL;
                    w_fill_cnt_nxt  = '0;
                    w_mem_cs_nxt    = 1'b1;
                    w_mem_we_nxt    = 4'hF;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = i_fill_value;
                end else if (i_req_valid) begin
                    w_state_nxt     = ACCESS;
                    w_mem_cs_nxt    = 1'b1;
                    w_mem_we_nxt    = i_req_we;
                    w_mem_addr_nxt  = i_req_addr;
                    w_mem_wdata_nxt = i_req_wdata;
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                // Stop on the last address instead of letting the counter
                // roll over, so a full-range fill ends cleanly.
                if (w_fill_last) begin
                    w_state_nxt    = IDLE;
                    w_fill_cnt_nxt = '0;
                end else begin
                    w_fill_cnt_nxt  = r_fill_cnt + ADDRWIDTH'(1);
                    w_mem_cs_nxt    = 1'b1;
                    w_mem_we_nxt    = 4'hF;
                    w_mem_addr_nxt  = r_fill_cnt + ADDRWIDTH'(1);
                    w_mem_wdata_nxt = r_mem_wdata;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and fill address counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    // Registered SRAM bus; everything drops to zero outside ACCESS/FILL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_cs    <= w_mem_cs_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Response data is captured at the end of the single ACCESS cycle and
    // then left untouched through RESP, so it stays stable under backpressure.
    // fill_done fires in the cycle after the last fill write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_rdata <= '0;
            r_fill_done <= 1'b0;
        end else begin
            if (r_state == ACCESS) begin
                r_rsp_rdata <= (r_mem_we == 4'h0) ? i_mem_rdata : '0;
            end
            r_fill_done <= (r_state == FILL) && w_fill_last;
        end
    end

    // req_ready is gated by rstn so it reads 0 while reset is held.
    assign o_req_ready = rstn && (r_state == IDLE) && !i_fill_start;
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_fill_busy = (r_state == FILL);
    assign o_fill_done = r_fill_done;
    assign o_mem_cs    = r_mem_cs;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
